// File: rtl/jtag_tap_param.sv
// jtag_tap_param: parametrised 1149.1 TAP with IDCODE, user data
// registers and IJTAG pass-through; TDO is retimed on falling TCK.
module jtag_tap_param #(
    parameter int                  IR_WIDTH     = 5,
    parameter logic [31:0]         IDCODE_VAL   = 32'h1CAFE0BF,
    parameter int                  NUM_UDR      = 4,
    parameter int                  UDR_WIDTH    = 32,
    parameter logic [IR_WIDTH-1:0] UDR_IR_BASE  = 5'h08,
    parameter logic [NUM_UDR-1:0]  UDR_CAP_MASK = 4'b1010,
    parameter logic [IR_WIDTH-1:0] IJTAG_IR     = 5'h10
) (
    input  logic                         TCK,
    input  logic                         TRST_n,
    input  logic                         TMS,
    input  logic                         TDI,
    output logic                         TDO,
    output logic                         TDO_en,
    output logic [3:0]                   tap_state,
    output logic [IR_WIDTH-1:0]          ir_q,
    output logic [NUM_UDR*UDR_WIDTH-1:0] udr_q,
    input  logic [NUM_UDR*UDR_WIDTH-1:0] udr_rdata,
    output logic [NUM_UDR-1:0]           udr_upd_stb,
    output logic                         ijtag_select,
    output logic                         ijtag_capture,
    output logic                         ijtag_shift,
    output logic                         ijtag_update,
    output logic                         ijtag_tdi,
    input  logic                         ijtag_tdo
);

    localparam int DRW = (UDR_WIDTH > 32) ? UDR_WIDTH : 32;

    typedef enum logic [3:0] {
        S_TLR, S_RTI, S_SEL_DR, S_CAP_DR,
        S_SH_DR, S_EX1_DR, S_PA_DR, S_EX2_DR,
        S_UPD_DR, S_SEL_IR, S_CAP_IR, S_SH_IR,
        S_EX1_IR, S_PA_IR, S_EX2_IR, S_UPD_IR
    } state_t;

    state_t                         r_state;
    state_t                         w_next;
    logic [IR_WIDTH-1:0]            r_ir_sr;
    logic [IR_WIDTH-1:0]            r_ir;
    logic [DRW-1:0]                 r_dr;
    logic                           r_bypass;
    logic [NUM_UDR*UDR_WIDTH-1:0]   r_udr;
    logic                           r_tdo;
    logic                           r_tdo_en;

    logic [NUM_UDR-1:0]             w_udr_sel;
    logic                           w_udr_any;
    logic                           w_idcode;
    logic                           w_ijtag;
    logic                           w_cap_dr;
    logic                           w_sh_dr;
    logic                           w_upd_dr;
    logic [DRW-1:0]                 w_dr_cap;
    logic [DRW-1:0]                 w_dr_shift;
    logic                           w_dr_lsb;

    always_ff @(posedge TCK or negedge TRST_n) begin
        if (!TRST_n) r_state <= S_TLR;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = S_TLR;
        unique case (r_state)
            S_TLR:    w_next = TMS ? S_TLR    : S_RTI;
            S_RTI:    w_next = TMS ? S_SEL_DR : S_RTI;
            S_SEL_DR: w_next = TMS ? S_SEL_IR : S_CAP_DR;
            S_CAP_DR: w_next = TMS ? S_EX1_DR : S_SH_DR;
            S_SH_DR:  w_next = TMS ? S_EX1_DR : S_SH_DR;
            S_EX1_DR: w_next = TMS ? S_UPD_DR : S_PA_DR;
            S_PA_DR:  w_next = TMS ? S_EX2_DR : S_PA_DR;
            S_EX2_DR: w_next = TMS ? S_UPD_DR : S_SH_DR;
            S_UPD_DR: w_next = TMS ? S_SEL_DR : S_RTI;
            S_SEL_IR: w_next = TMS ? S_TLR    : S_CAP_IR;
            S_CAP_IR: w_next = TMS ? S_EX1_IR : S_SH_IR;
            S_SH_IR:  w_next = TMS ? S_EX1_IR : S_SH_IR;
            S_EX1_IR: w_next = TMS ? S_UPD_IR : S_PA_IR;
            S_PA_IR:  w_next = TMS ? S_EX2_IR : S_PA_IR;
            S_EX2_IR: w_next = TMS ? S_UPD_IR : S_SH_IR;
            S_UPD_IR: w_next = TMS ? S_SEL_DR : S_RTI;
            default:  w_next = S_TLR;
        endcase
    end

    always_comb begin
        w_cap_dr      = (r_state == S_CAP_DR);
        w_sh_dr       = (r_state == S_SH_DR);
        w_upd_dr      = (r_state == S_UPD_DR);
        udr_upd_stb   = w_upd_dr ? w_udr_sel : '0;
        ijtag_capture = w_ijtag & w_cap_dr;
        ijtag_shift   = w_ijtag & w_sh_dr;
        ijtag_update  = w_ijtag & w_upd_dr;
    end

    // Unlisted opcodes fall through to bypass by selecting nothing else
    always_comb begin
        w_udr_sel = '0;
        for (int k = 0; k < NUM_UDR; k++)
            w_udr_sel[k] = (r_ir == UDR_IR_BASE + IR_WIDTH'(k));
    end

    assign w_udr_any = |w_udr_sel;
    assign w_idcode  = (r_ir == IR_WIDTH'(1));
    assign w_ijtag   = (r_ir == IJTAG_IR);

    always_comb begin
        w_dr_cap = '0;
        if (w_idcode) w_dr_cap[31:0] = IDCODE_VAL;
        for (int k = 0; k < NUM_UDR; k++) begin
            if (w_udr_sel[k])
                w_dr_cap[UDR_WIDTH-1:0] = UDR_CAP_MASK[k]
                    ? udr_rdata[k*UDR_WIDTH +: UDR_WIDTH]
                    : r_udr[k*UDR_WIDTH +: UDR_WIDTH];
        end
    end

    always_comb begin
        w_dr_shift = r_dr >> 1;
        if (w_udr_any) w_dr_shift[UDR_WIDTH-1] = TDI;
        else           w_dr_shift[31]          = TDI;
    end

    always_ff @(posedge TCK or negedge TRST_n) begin
        if (!TRST_n) begin
            r_ir_sr <= IR_WIDTH'(1);
            r_ir    <= IR_WIDTH'(1);
        end else begin
            if (r_state == S_CAP_IR)
                r_ir_sr <= IR_WIDTH'(1);
            else if (r_state == S_SH_IR)
                r_ir_sr <= {TDI, r_ir_sr[IR_WIDTH-1:1]};
            if (r_state == S_TLR)
                r_ir <= IR_WIDTH'(1);
            else if (r_state == S_UPD_IR)
                r_ir <= r_ir_sr;
        end
    end

    always_ff @(posedge TCK or negedge TRST_n) begin
        if (!TRST_n) begin
            r_dr     <= '0;
            r_bypass <= 1'b0;
            r_udr    <= '0;
        end else begin
            if (w_cap_dr) begin
                r_dr     <= w_dr_cap;
                r_bypass <= 1'b0;
            end else if (w_sh_dr) begin
                r_dr     <= w_dr_shift;
                r_bypass <= TDI;
            end
            for (int k = 0; k < NUM_UDR; k++) begin
                if (w_upd_dr && w_udr_sel[k])
                    r_udr[k*UDR_WIDTH +: UDR_WIDTH] <= r_dr[UDR_WIDTH-1:0];
            end
        end
    end

    assign w_dr_lsb = w_ijtag                ? ijtag_tdo :
                      (w_udr_any | w_idcode) ? r_dr[0]   : r_bypass;

    always_ff @(negedge TCK or negedge TRST_n) begin
        if (!TRST_n) begin
            r_tdo    <= 1'b0;
            r_tdo_en <= 1'b0;
        end else if (r_state == S_SH_IR) begin
            r_tdo    <= r_ir_sr[0];
            r_tdo_en <= 1'b1;
        end else if (r_state == S_SH_DR) begin
            r_tdo    <= w_dr_lsb;
            r_tdo_en <= 1'b1;
        end else begin
            r_tdo    <= 1'b0;
            r_tdo_en <= 1'b0;
        end
    end

    assign TDO          = r_tdo;
    assign TDO_en       = r_tdo_en;
    assign tap_state    = r_state;
    assign ir_q         = r_ir;
    assign udr_q        = r_udr;
    assign ijtag_select = w_ijtag;
    assign ijtag_tdi    = TDI;

endmodule

// File: tb/tb_jtag_tap_param.sv
// tb_jtag_tap_param: random scans against a bit-level model of
// what each instruction's data register should return and hold.
module tb_jtag_tap_param;

    localparam int IRW = 5;
    localparam int NU  = 4;
    localparam int UW  = 32;

    logic TCK = 1'b0;
    logic TRST_n = 1'b1;
    logic TMS = 1'b1;
    logic TDI = 1'b0;
    logic TDO, TDO_en;
    logic [3:0] tap_state;
    logic [IRW-1:0] ir_q;
    logic [NU*UW-1:0] udr_q;
    logic [NU*UW-1:0] udr_rdata = '0;
    logic [NU-1:0] udr_upd_stb;
    logic ijtag_select, ijtag_capture, ijtag_shift, ijtag_update;
    logic ijtag_tdi;
    logic ijtag_tdo = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] idc = 32'h1CAFE0BF;
    logic [3:0]  capm = 4'b1010;
    logic [UW-1:0] m_udr [NU];

    jtag_tap_param #(
        .IR_WIDTH(5), .IDCODE_VAL(32'h1CAFE0BF), .NUM_UDR(4),
        .UDR_WIDTH(32), .UDR_IR_BASE(5'h08),
        .UDR_CAP_MASK(4'b1010), .IJTAG_IR(5'h10)
    ) dut (
        .TCK(TCK), .TRST_n(TRST_n), .TMS(TMS), .TDI(TDI),
        .TDO(TDO), .TDO_en(TDO_en), .tap_state(tap_state),
        .ir_q(ir_q), .udr_q(udr_q), .udr_rdata(udr_rdata),
        .udr_upd_stb(udr_upd_stb), .ijtag_select(ijtag_select),
        .ijtag_capture(ijtag_capture), .ijtag_shift(ijtag_shift),
        .ijtag_update(ijtag_update), .ijtag_tdi(ijtag_tdi),
        .ijtag_tdo(ijtag_tdo)
    );

    always #5 TCK = ~TCK;

    initial begin
        #200000;
        $display("FAIL watchdog: run still going at %0t, want done", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [NU*UW-1:0] pack_udr();
        logic [NU*UW-1:0] p;
        for (int k = 0; k < NU; k++) p[k*UW +: UW] = m_udr[k];
        return p;
    endfunction

    function automatic logic [63:0] exp_cap(input logic [IRW-1:0] op);
        logic [63:0] c;
        int k;
        c = '0;
        if (op == 5'h01) c[31:0] = idc;
        else if (op >= 5'h08 && op <= 5'h0B) begin
            k = int'(op) - 8;
            c[31:0] = capm[k] ? udr_rdata[k*UW +: UW] : m_udr[k];
        end
        return c;
    endfunction

    // Bits seen on TDO: L captured bits, then TDI delayed by L
    function automatic logic [63:0] exp_out(input logic [63:0] cap,
        input int len, input logic [63:0] din, input int n);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < n; i++)
            o[i] = (i < len) ? cap[i] : din[i-len];
        return o;
    endfunction

    function automatic logic [31:0] exp_reg(input logic [63:0] cap,
        input logic [63:0] din, input int n);
        logic [31:0] r;
        for (int j = 0; j < 32; j++)
            r[j] = (j + n < 32) ? cap[j+n] : din[j+n-32];
        return r;
    endfunction

    task automatic tick(input logic tms, input logic tdi,
        output logic tdo, output logic en);
        TMS = tms;
        TDI = tdi;
        @(negedge TCK);
        #1;
        tdo = TDO;
        en  = TDO_en;
        @(posedge TCK);
        #1;
    endtask

    task automatic go_rti();
        logic t, e;
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, t, e);
        tick(1'b0, 1'b0, t, e);
    endtask

    task automatic ir_scan(input logic [IRW-1:0] op,
        output logic [IRW-1:0] cap);
        logic t, e;
        tick(1'b1, 1'b0, t, e);
        tick(1'b1, 1'b0, t, e);
        tick(1'b0, 1'b0, t, e);
        tick(1'b0, 1'b0, t, e);
        for (int i = 0; i < IRW; i++) begin
            tick(i == IRW-1, op[i], t, e);
            cap[i] = t;
        end
        tick(1'b1, 1'b0, t, e);
        tick(1'b0, 1'b0, t, e);
    endtask

    // jfl: [0] capture in CAP, [1] shift held in SH, [2] update in UPD,
    // [3] any ijtag strobe seen in other states
    task automatic dr_scan(input int n, input logic [63:0] din,
        input logic [63:0] jdo, output logic [63:0] dout,
        output logic en_ok, output logic [NU-1:0] stb,
        output logic [3:0] jfl);
        logic t, e;
        dout  = '0;
        en_ok = 1'b1;
        jfl   = 4'b0010;
        tick(1'b1, 1'b0, t, e);
        en_ok &= !e;
        jfl[3] = ijtag_capture | ijtag_shift | ijtag_update;
        tick(1'b0, 1'b0, t, e);
        en_ok &= !e;
        jfl[0] = ijtag_capture;
        if (n == 0) begin
            tick(1'b1, 1'b0, t, e);
            en_ok &= !e;
            jfl[1] = 1'b0;
        end else begin
            tick(1'b0, 1'b0, t, e);
            en_ok &= !e;
            for (int i = 0; i < n; i++) begin
                jfl[1] &= ijtag_shift;
                ijtag_tdo = jdo[i];
                tick(i == n-1, din[i], t, e);
                dout[i] = t;
                en_ok &= e;
            end
        end
        jfl[3] |= ijtag_capture | ijtag_shift | ijtag_update;
        tick(1'b1, 1'b0, t, e);
        en_ok &= !e;
        stb    = udr_upd_stb;
        jfl[2] = ijtag_update;
        tick(1'b0, 1'b0, t, e);
        en_ok &= !e;
        jfl[3] |= ijtag_capture | ijtag_shift | ijtag_update;
    endtask

    task automatic test_reset();
        TRST_n = 1'b0;
        #2;
        n_cmp++;
        if (tap_state !== 4'h0) begin
            n_bad++;
            $display("FAIL rst_state: got %h want 0", tap_state);
        end
        n_cmp++;
        if (ir_q !== 5'h01) begin
            n_bad++;
            $display("FAIL rst_ir: got %h want 01", ir_q);
        end
        n_cmp++;
        if (udr_q !== '0 || udr_upd_stb !== 4'h0) begin
            n_bad++;
            $display("FAIL rst_udr: got %h/%h want 0", udr_q, udr_upd_stb);
        end
        n_cmp++;
        if ({TDO, TDO_en, ijtag_capture, ijtag_shift, ijtag_update} !== 5'b0) begin
            n_bad++;
            $display("FAIL rst_outs: got %b%b%b%b%b want 00000",
                TDO, TDO_en, ijtag_capture, ijtag_shift, ijtag_update);
        end
        @(posedge TCK);
        #1;
        TRST_n = 1'b1;
    endtask

    task automatic test_tms_reset();
        logic t, e;
        for (int it = 0; it < 6; it++) begin
            int len;
            len = $urandom_range(0, 25);
            for (int i = 0; i < len; i++)
                tick(1'($urandom), 1'($urandom), t, e);
            for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, t, e);
            n_cmp++;
            if (tap_state !== 4'h0 || ir_q !== 5'h01) begin
                n_bad++;
                $display("FAIL tms_reset: got st=%h ir=%h want 0/01",
                    tap_state, ir_q);
            end
        end
        TRST_n = 1'b0;
        #1;
        @(posedge TCK);
        #1;
        TRST_n = 1'b1;
        for (int k = 0; k < NU; k++) m_udr[k] = '0;
    endtask

    task automatic test_idcode();
        logic [63:0] din, dout, eo;
        logic en;
        logic [NU-1:0] stb;
        logic [3:0] jf;
        go_rti();
        din = {$urandom, $urandom};
        dr_scan(32, din, '0, dout, en, stb, jf);
        n_cmp++;
        if (dout[31:0] !== idc) begin
            n_bad++;
            $display("FAIL idcode: got %h want %h", dout[31:0], idc);
        end
        n_cmp++;
        if (en !== 1'b1) begin
            n_bad++;
            $display("FAIL idcode_en: got %b want 1", en);
        end
        din = {$urandom, $urandom};
        dr_scan(40, din, '0, dout, en, stb, jf);
        eo = exp_out({32'h0, idc}, 32, din, 40);
        n_cmp++;
        if (dout !== eo) begin
            n_bad++;
            $display("FAIL idcode_over: got %h want %h", dout, eo);
        end
    endtask

    task automatic test_udr();
        for (int it = 0; it < 8; it++) begin
            int k, n;
            logic [IRW-1:0] op, c;
            logic [63:0] din, cap, dout, eo;
            logic en;
            logic [NU-1:0] stb;
            logic [3:0] jf;
            k = (it < 2) ? it : int'($urandom_range(0, 3));
            udr_rdata = {$urandom, $urandom, $urandom, $urandom};
            if (it == 1) udr_rdata[32 +: 32] = 32'h12345678;
            din = {$urandom, $urandom};
            if (it == 0) din[31:0] = 32'hA5A50F0F;
            n = (it < 2) ? 32 : int'($urandom_range(0, 40));
            op = 5'(8 + k);
            ir_scan(op, c);
            n_cmp++;
            if (c !== 5'b00001) begin
                n_bad++;
                $display("FAIL ir_cap: got %b want 00001", c);
            end
            cap = exp_cap(op);
            dr_scan(n, din, '0, dout, en, stb, jf);
            eo = exp_out(cap, 32, din, n);
            n_cmp++;
            if (dout !== eo || en !== 1'b1) begin
                n_bad++;
                $display("FAIL udr%0d_tdo n=%0d: got %h en=%b want %h en=1",
                    k, n, dout, en, eo);
            end
            if (it == 1) begin
                n_cmp++;
                if (dout[31:0] !== 32'h12345678) begin
                    n_bad++;
                    $display("FAIL udr1_rdata: got %h want 12345678", dout[31:0]);
                end
            end
            n_cmp++;
            if (stb !== 4'(1 << k)) begin
                n_bad++;
                $display("FAIL udr_stb: got %b want %b", stb, 4'(1 << k));
            end
            m_udr[k] = exp_reg(cap, din, n);
            n_cmp++;
            if (udr_q !== pack_udr() || udr_upd_stb !== 4'h0) begin
                n_bad++;
                $display("FAIL udr_q: got %h stb=%b want %h stb=0",
                    udr_q, udr_upd_stb, pack_udr());
            end
            if (it == 0) begin
                n_cmp++;
                if (udr_q[31:0] !== 32'hA5A50F0F) begin
                    n_bad++;
                    $display("FAIL udr0_wr: got %h want A5A50F0F", udr_q[31:0]);
                end
            end
            if (!capm[k]) begin
                dr_scan(32, {32'h0, m_udr[k]}, '0, dout, en, stb, jf);
                n_cmp++;
                if (dout[31:0] !== m_udr[k]) begin
                    n_bad++;
                    $display("FAIL udr_readback: got %h want %h",
                        dout[31:0], m_udr[k]);
                end
            end
        end
    endtask

    task automatic test_bypass();
        logic [IRW-1:0] c, op;
        logic [63:0] din, dout, eo;
        logic en;
        logic [NU-1:0] stb;
        logic [3:0] jf;
        int n;
        ir_scan(5'h03, c);
        n_cmp++;
        if (c !== 5'b00001) begin
            n_bad++;
            $display("FAIL byp_ircap: got %b want 00001", c);
        end
        dr_scan(4, 64'hD, '0, dout, en, stb, jf);
        n_cmp++;
        if (dout !== 64'hA) begin
            n_bad++;
            $display("FAIL byp_1011: got %h want a", dout);
        end
        for (int j = 0; j < 6; j++) begin
            if (j == 0) op = 5'h00;
            else if (j == 1) op = 5'h1F;
            else begin
                do op = 5'($urandom_range(0, 31));
                while (op == 5'h01 || (op >= 5'h08 && op <= 5'h0B) || op == 5'h10);
            end
            ir_scan(op, c);
            n   = $urandom_range(1, 20);
            din = {$urandom, $urandom};
            dr_scan(n, din, '0, dout, en, stb, jf);
            eo = exp_out('0, 1, din, n);
            n_cmp++;
            if (dout !== eo || stb !== 4'h0 || jf !== 4'h0) begin
                n_bad++;
                $display("FAIL byp_op%h: got %h stb=%b jf=%b want %h 0 0",
                    op, dout, stb, jf, eo);
            end
            n_cmp++;
            if (udr_q !== pack_udr()) begin
                n_bad++;
                $display("FAIL byp_udr: got %h want %h", udr_q, pack_udr());
            end
        end
    endtask

    task automatic test_ijtag();
        logic [IRW-1:0] c;
        logic [63:0] din, jdo, dout, eo;
        logic en;
        logic [NU-1:0] stb;
        logic [3:0] jf;
        int n;
        ir_scan(5'h10, c);
        n_cmp++;
        if (ijtag_select !== 1'b1) begin
            n_bad++;
            $display("FAIL ij_sel: got %b want 1", ijtag_select);
        end
        n   = $urandom_range(8, 24);
        din = {$urandom, $urandom};
        jdo = {$urandom, $urandom};
        dr_scan(n, din, jdo, dout, en, stb, jf);
        eo = jdo & ((64'd1 << n) - 64'd1);
        n_cmp++;
        if (dout !== eo || en !== 1'b1) begin
            n_bad++;
            $display("FAIL ij_tdo: got %h en=%b want %h en=1", dout, en, eo);
        end
        n_cmp++;
        if (jf !== 4'b0111 || stb !== 4'h0) begin
            n_bad++;
            $display("FAIL ij_strobes: got %b stb=%b want 0111 0", jf, stb);
        end
        TDI = 1'b1;
        #1;
        n_cmp++;
        if (ijtag_tdi !== 1'b1) begin
            n_bad++;
            $display("FAIL ij_tdi: got %b want 1", ijtag_tdi);
        end
        TDI = 1'b0;
        ir_scan(5'h01, c);
        n_cmp++;
        if (ijtag_select !== 1'b0 || ir_q !== 5'h01) begin
            n_bad++;
            $display("FAIL ij_desel: got %b ir=%h want 0 01", ijtag_select, ir_q);
        end
    endtask

    task automatic test_pause();
        logic [IRW-1:0] c;
        logic [31:0] val, cap, dout;
        logic t, e;
        ir_scan(5'h08, c);
        val = $urandom;
        cap = m_udr[0];
        tick(1'b1, 1'b0, t, e);
        tick(1'b0, 1'b0, t, e);
        tick(1'b0, 1'b0, t, e);
        for (int i = 0; i < 16; i++) begin
            tick(i == 15, val[i], t, e);
            dout[i] = t;
        end
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, t, e);
        n_cmp++;
        if (tap_state !== 4'h6) begin
            n_bad++;
            $display("FAIL pause_state: got %h want 6", tap_state);
        end
        tick(1'b1, 1'b0, t, e);
        tick(1'b0, 1'b0, t, e);
        for (int i = 16; i < 32; i++) begin
            tick(i == 31, val[i], t, e);
            dout[i] = t;
        end
        tick(1'b1, 1'b0, t, e);
        n_cmp++;
        if (udr_upd_stb !== 4'b0001) begin
            n_bad++;
            $display("FAIL pause_stb: got %b want 0001", udr_upd_stb);
        end
        tick(1'b0, 1'b0, t, e);
        m_udr[0] = val;
        n_cmp++;
        if (dout !== cap || udr_q !== pack_udr()) begin
            n_bad++;
            $display("FAIL pause_data: got %h/%h want %h/%h",
                dout, udr_q, cap, pack_udr());
        end
        ir_scan(5'h08, c);
        tick(1'b1, 1'b0, t, e);
        tick(1'b0, 1'b0, t, e);
        tick(1'b0, 1'b0, t, e);
        for (int i = 0; i < 20; i++) tick(1'b0, 1'($urandom), t, e);
        TRST_n = 1'b0;
        #1;
        for (int k = 0; k < NU; k++) m_udr[k] = '0;
        n_cmp++;
        if (tap_state !== 4'h0 || udr_q !== pack_udr()
            || udr_upd_stb !== 4'h0 || TDO_en !== 1'b0) begin
            n_bad++;
            $display("FAIL trst_abort: got st=%h udr=%h stb=%b en=%b want 0 0 0 0",
                tap_state, udr_q, udr_upd_stb, TDO_en);
        end
        @(posedge TCK);
        #1;
        TRST_n = 1'b1;
        go_rti();
        n_cmp++;
        if (udr_q !== pack_udr() || ir_q !== 5'h01) begin
            n_bad++;
            $display("FAIL trst_after: got %h ir=%h want 0 01", udr_q, ir_q);
        end
    endtask

    initial begin
        for (int k = 0; k < NU; k++) m_udr[k] = '0;
        #1;
        test_reset();
        test_tms_reset();
        test_idcode();
        test_udr();
        test_bypass();
        test_ijtag();
        test_pause();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
